// File: rtl/uart_receiver_parity.sv
// Parity UART receiver: start, 8 data bits LSB first, even parity, stop.
// Delivers each byte with parity/framing/overrun flags over valid/ready.
module uart_receiver_parity #(
  parameter int BIT_CLKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d,
  input  logic       ready,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = (BIT_CLKS - 1) / 2;
  localparam logic [15:0] RELOAD = 16'(BIT_CLKS - 1);
  localparam logic [15:0] HALF_LD = 16'((HALF > 0) ? HALF - 1 : 0);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par;
  logic        cnt_zero;

  assign cnt_zero = (clk_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WAIT_HIGH;
      clk_cnt    <= 16'd0;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      par        <= 1'b0;
      dout       <= 8'd0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (valid && ready) valid <= 1'b0;
      unique case (state)
        WAIT_HIGH: begin
          if (d) state <= IDLE;
        end
        IDLE: begin
          if (!d) begin
            busy    <= 1'b1;
            bit_cnt <= 3'd0;
            if (HALF == 0) begin
              state   <= DATA;
              clk_cnt <= RELOAD;
            end else begin
              state   <= START;
              clk_cnt <= HALF_LD;
            end
          end
        end
        START: begin
          if (!cnt_zero) begin
            clk_cnt <= clk_cnt - 16'd1;
          end else if (!d) begin
            state   <= DATA;
            clk_cnt <= RELOAD;
            bit_cnt <= 3'd0;
          end else begin
            // start bit did not hold through mid-bit: treat as glitch
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: begin
          if (!cnt_zero) begin
            clk_cnt <= clk_cnt - 16'd1;
          end else begin
            shift   <= {d, shift[7:1]};
            clk_cnt <= RELOAD;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
        end
        PARITY: begin
          if (!cnt_zero) begin
            clk_cnt <= clk_cnt - 16'd1;
          end else begin
            par     <= d;
            clk_cnt <= RELOAD;
            state   <= STOP;
          end
        end
        STOP: begin
          if (!cnt_zero) begin
            clk_cnt <= clk_cnt - 16'd1;
          end else begin
            dout       <= shift;
            parity_err <= (par != ^shift);
            frame_err  <= ~d;
            overrun    <= valid & ~ready;
            valid      <= 1'b1;
            busy       <= 1'b0;
            // a low stop may be a break: wait for mark before hunting starts
            state      <= d ? IDLE : WAIT_HIGH;
          end
        end
        default: begin
          state <= WAIT_HIGH;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver_parity.sv
// Directed bench for uart_receiver_parity at 1 and 16 clocks per bit.
// Expected values are hand-computed per frame.
module tb_uart_receiver_parity;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       d_a = 1'b1, ready_a = 1'b1;
  logic [7:0] dout_a;
  logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;

  logic       d_b = 1'b1, ready_b = 1'b0;
  logic [7:0] dout_b;
  logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

  int checks = 0;
  int failures = 0;
  int hits;

  uart_receiver_parity #(.BIT_CLKS(1)) u_a (
    .clk(clk), .rst(rst), .d(d_a), .ready(ready_a),
    .dout(dout_a), .valid(valid_a), .parity_err(perr_a),
    .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a)
  );

  uart_receiver_parity #(.BIT_CLKS(16)) u_b (
    .clk(clk), .rst(rst), .d(d_b), .ready(ready_b),
    .dout(dout_b), .valid(valid_b), .parity_err(perr_b),
    .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b, input logic p, input logic s);
    d_a = 1'b0;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      d_a = b[i];
      tick(1);
    end
    d_a = p;
    tick(1);
    d_a = s;
    tick(1);
  endtask

  initial begin
    tick(3);
    check("rst_dout", {8'h0, dout_a}, 16'h0);
    check("rst_flags", {11'h0, valid_a, perr_a, ferr_a, ovr_a, busy_a}, 16'h0);
    rst = 1'b1;
    tick(3);

    // 0xA5, correct parity 0
    send_a(8'hA5, 1'b0, 1'b1);
    check("a5_valid", {15'h0, valid_a}, 16'h1);
    check("a5_dout", {8'h0, dout_a}, 16'h00A5);
    check("a5_flags", {13'h0, perr_a, ferr_a, ovr_a}, 16'h0);
    tick(1);
    check("a5_pulse", {15'h0, valid_a}, 16'h0);

    // 0x07 needs parity 1, sent 0
    send_a(8'h07, 1'b0, 1'b1);
    check("07_dout", {8'h0, dout_a}, 16'h0007);
    check("07_perr", {15'h0, perr_a}, 16'h1);
    check("07_ferr", {15'h0, ferr_a}, 16'h0);
    tick(1);

    // 0x3C with low stop, then break
    send_a(8'h3C, 1'b0, 1'b0);
    check("3c_dout", {8'h0, dout_a}, 16'h003C);
    check("3c_ferr", {15'h0, ferr_a}, 16'h1);
    check("3c_perr", {15'h0, perr_a}, 16'h0);
    tick(1);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_a || busy_a) hits++;
      tick(1);
    end
    check("break_quiet", 16'(hits), 16'h0);
    d_a = 1'b1;
    tick(2);
    send_a(8'h11, 1'b0, 1'b1);
    check("11_valid", {15'h0, valid_a}, 16'h1);
    check("11_dout", {8'h0, dout_a}, 16'h0011);
    check("11_flags", {14'h0, perr_a, ferr_a}, 16'h0);
    tick(1);

    // back-to-back with ready low
    ready_a = 1'b0;
    send_a(8'h12, 1'b0, 1'b1);
    check("12_dout", {8'h0, dout_a}, 16'h0012);
    check("12_ovr", {15'h0, ovr_a}, 16'h0);
    send_a(8'h34, 1'b1, 1'b1);
    check("34_valid", {15'h0, valid_a}, 16'h1);
    check("34_dout", {8'h0, dout_a}, 16'h0034);
    check("34_ovr", {15'h0, ovr_a}, 16'h1);
    ready_a = 1'b1;
    tick(1);
    ready_a = 1'b0;
    check("34_drop", {15'h0, valid_a}, 16'h0);
    check("34_hold", {8'h0, dout_a}, 16'h0034);

    // 16 clocks per bit: short glitch
    d_b = 1'b0;
    tick(3);
    check("glitch_busy", {15'h0, busy_b}, 16'h1);
    d_b = 1'b1;
    tick(10);
    check("glitch_idle", {15'h0, busy_b}, 16'h0);
    check("glitch_nv", {15'h0, valid_b}, 16'h0);

    // full 0x5A frame at 16 clocks per bit
    d_b = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      d_b = 8'h5A >> i;
      tick(16);
    end
    d_b = 1'b0;
    tick(16);
    d_b = 1'b1;
    tick(7);
    check("5a_early", {15'h0, valid_b}, 16'h0);
    tick(1);
    check("5a_valid", {15'h0, valid_b}, 16'h1);
    check("5a_dout", {8'h0, dout_b}, 16'h005A);
    check("5a_flags", {13'h0, perr_b, ferr_b, ovr_b}, 16'h0);

    // reset in the middle of 0xFF
    ready_a = 1'b1;
    d_a = 1'b0;
    tick(1);
    d_a = 1'b1;
    tick(3);
    check("ff_busy", {15'h0, busy_a}, 16'h1);
    d_a = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_dout", {8'h0, dout_a}, 16'h0);
    check("abort_flags", {11'h0, valid_a, perr_a, ferr_a, ovr_a, busy_a}, 16'h0);
    tick(2);
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid_a || busy_a) hits++;
      tick(1);
    end
    check("low_after_rst", 16'(hits), 16'h0);
    d_a = 1'b1;
    tick(2);
    send_a(8'h81, 1'b0, 1'b1);
    check("81_valid", {15'h0, valid_a}, 16'h1);
    check("81_dout", {8'h0, dout_a}, 16'h0081);
    check("81_flags", {13'h0, perr_a, ferr_a, ovr_a}, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
